// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory arbiter.
package mem_arb_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_XFER = 2'd1,
    D_XFER = 2'd2
  } state_t;

  // Side that received the most recent grant (round-robin pointer).
  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_side_t;

  localparam int WORD_BYTES = 4;

  // Ceiling log2, used for beat-index and line-offset widths.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/mem_arb.sv
// Two-way round-robin arbiter that moves whole cache lines, one beat at a
// time, between the icache/dcache and the single main-memory port.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  // icache side
  input  logic                           i_ic_req,
  input  logic [ADDR_W-1:0]              i_ic_addr,
  output logic                           o_ic_gnt,
  output logic                           o_ic_rvalid,
  output logic [31:0]                    o_ic_rdata,
  output logic                           o_ic_done,
  // dcache side
  input  logic                           i_dc_req,
  input  logic                           i_dc_we,
  input  logic [ADDR_W-1:0]              i_dc_addr,
  input  logic [31:0]                    i_dc_wdata,
  output logic [clog2(LINE_WORDS)-1:0]   o_dc_beat,
  output logic                           o_dc_gnt,
  output logic                           o_dc_rvalid,
  output logic [31:0]                    o_dc_rdata,
  output logic                           o_dc_done,
  // main-memory port
  output logic                           o_mem_req,
  output logic                           o_mem_we,
  output logic [ADDR_W-1:0]              o_mem_addr,
  output logic [31:0]                    o_mem_wdata,
  input  logic                           i_mem_ready,
  input  logic [31:0]                    i_mem_rdata
);

  localparam int BEAT_W = clog2(LINE_WORDS);
  localparam int BYTE_W = clog2(WORD_BYTES);
  localparam int OFF_W  = BEAT_W + BYTE_W;

  // Clears the byte-in-line offset so every burst starts on a line boundary.
  localparam logic [ADDR_W-1:0] BASE_MASK = {ADDR_W{1'b1}} << OFF_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  state_t            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              we_q, we_d;
  gnt_side_t         last_q, last_d;

  logic [ADDR_W-1:0] beat_off;
  logic              is_dc;
  logic              last_beat;

  assign beat_off  = ADDR_W'(beat_q) << BYTE_W;
  assign is_dc     = (state_q == D_XFER);
  assign last_beat = (beat_q == LAST_BEAT);

  // State, beat counter, latched burst parameters and round-robin pointer.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; the combinational block below uses blocking (=).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      base_q  <= '0;
      we_q    <= 1'b0;
      last_q  <= GNT_I;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
      we_q    <= we_d;
      last_q  <= last_d;
    end
  end

  // Grant decision in IDLE, beat sequencing in XFER, and all port outputs.
  // NOTE: every signal gets a default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    base_d      = base_q;
    we_d        = we_q;
    last_d      = last_q;

    o_ic_gnt    = 1'b0;
    o_ic_rvalid = 1'b0;
    o_ic_rdata  = '0;
    o_ic_done   = 1'b0;
    o_dc_gnt    = 1'b0;
    o_dc_rvalid = 1'b0;
    o_dc_rdata  = '0;
    o_dc_done   = 1'b0;
    o_dc_beat   = beat_q;
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;

    unique case (state_q)
      IDLE: begin
        // On a tie, the side that did not go last wins.
        if (i_dc_req && (!i_ic_req || last_q == GNT_I)) begin
          state_d = D_XFER;
          base_d  = i_dc_addr & BASE_MASK;
          we_d    = i_dc_we;
          beat_d  = '0;
          last_d  = GNT_D;
        end else if (i_ic_req) begin
          state_d = I_XFER;
          base_d  = i_ic_addr & BASE_MASK;
          we_d    = 1'b0;
          beat_d  = '0;
          last_d  = GNT_I;
        end
      end

      I_XFER, D_XFER: begin
        o_mem_req  = 1'b1;
        o_mem_we   = we_q;
        o_mem_addr = base_q + beat_off;
        o_ic_gnt   = !is_dc;
        o_dc_gnt   = is_dc;
        if (is_dc) o_mem_wdata = i_dc_wdata;

        if (i_mem_ready) begin
          // Read data is passed straight through; the cache must take it now.
          if (!we_q) begin
            o_ic_rvalid = !is_dc;
            o_dc_rvalid = is_dc;
            if (is_dc) o_dc_rdata = i_mem_rdata;
            else       o_ic_rdata = i_mem_rdata;
          end
          if (last_beat) begin
            o_ic_done = !is_dc;
            o_dc_done = is_dc;
            state_d   = IDLE;
            beat_d    = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arb.sv
// Directed self-checking bench for mem_arb with LINE_WORDS = 4.
module tb_mem_arb;

  localparam int LINE_WORDS = 4;
  localparam int ADDR_W     = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_gnt, ic_rvalid, ic_done;
  logic [31:0] ic_rdata;
  logic        dc_req, dc_we;
  logic [31:0] dc_addr, dc_wdata;
  logic [1:0]  dc_beat;
  logic        dc_gnt, dc_rvalid, dc_done;
  logic [31:0] dc_rdata;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int vectors = 0;
  int errs    = 0;

  mem_arb #(.LINE_WORDS(LINE_WORDS), .ADDR_W(ADDR_W)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_ic_req    (ic_req),
    .i_ic_addr   (ic_addr),
    .o_ic_gnt    (ic_gnt),
    .o_ic_rvalid (ic_rvalid),
    .o_ic_rdata  (ic_rdata),
    .o_ic_done   (ic_done),
    .i_dc_req    (dc_req),
    .i_dc_we     (dc_we),
    .i_dc_addr   (dc_addr),
    .i_dc_wdata  (dc_wdata),
    .o_dc_beat   (dc_beat),
    .o_dc_gnt    (dc_gnt),
    .o_dc_rvalid (dc_rvalid),
    .o_dc_rdata  (dc_rdata),
    .o_dc_done   (dc_done),
    .o_mem_req   (mem_req),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .i_mem_ready (mem_ready),
    .i_mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // dcache writeback buffer: word for each beat is 0xA0 + beat index.
  assign dc_wdata = 32'hA0 + 32'(dc_beat);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    check({tag, " mem_req"}, mem_req, 0);
    check({tag, " ic_gnt"},  ic_gnt,  0);
    check({tag, " dc_gnt"},  dc_gnt,  0);
    next_cycle();
  endtask

  // Zero-wait-state burst; optionally drops ic_req after beat drop_ic_at.
  task automatic burst(input string tag, input bit side_d, input logic [31:0] base,
                       input bit we, input int nbeats, input int drop_ic_at);
    for (int b = 0; b < nbeats; b++) begin
      mem_ready = 1'b1;
      mem_rdata = 32'h5A00_0000 + base + 32'(b);
      @(negedge clk);
      check($sformatf("%s b%0d mem_req", tag, b), mem_req, 1);
      check($sformatf("%s b%0d addr", tag, b), mem_addr, base + 32'(4 * b));
      check($sformatf("%s b%0d we", tag, b), mem_we, we);
      check($sformatf("%s b%0d ic_gnt", tag, b), ic_gnt, !side_d);
      check($sformatf("%s b%0d dc_gnt", tag, b), dc_gnt, side_d);
      check($sformatf("%s b%0d ic_rvalid", tag, b), ic_rvalid, !side_d);
      check($sformatf("%s b%0d dc_rvalid", tag, b), dc_rvalid, side_d && !we);
      check($sformatf("%s b%0d ic_done", tag, b), ic_done, !side_d && b == 3);
      check($sformatf("%s b%0d dc_done", tag, b), dc_done, side_d && b == 3);
      if (side_d) begin
        check($sformatf("%s b%0d dc_beat", tag, b), dc_beat, 32'(b));
        if (!we) check($sformatf("%s b%0d dc_rdata", tag, b), dc_rdata, 32'h5A00_0000 + base + 32'(b));
      end else begin
        check($sformatf("%s b%0d ic_rdata", tag, b), ic_rdata, 32'h5A00_0000 + base + 32'(b));
      end
      next_cycle();
      if (b == drop_ic_at) ic_req = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; ic_req = 0; ic_addr = 0; dc_req = 0; dc_we = 0; dc_addr = 0;
    mem_ready = 0; mem_rdata = 0;

    // Reset state
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("rst mem_req", mem_req, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst ic_gnt", ic_gnt, 0);
    check("rst dc_gnt", dc_gnt, 0);
    check("rst ic_done", ic_done, 0);
    check("rst dc_done", dc_done, 0);
    check("rst dc_beat", dc_beat, 0);
    next_cycle();
    rst = 1'b0;

    // T1: single icache fill at 0x1234, memory always ready
    ic_req = 1'b1; ic_addr = 32'h0000_1234; mem_ready = 1'b1;
    idle_check("t1 idle");
    burst("t1", 1'b0, 32'h0000_1230, 1'b0, 4, -1);
    ic_req = 1'b0;
    idle_check("t1 after");

    // T2: simultaneous requests after reset alternate D, I, D, I
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    ic_req = 1'b1; ic_addr = 32'h0000_1000;
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h0000_3000;
    idle_check("t2 idle0");
    burst("t2 d0", 1'b1, 32'h0000_3000, 1'b0, 4, -1);
    idle_check("t2 idle1");
    burst("t2 i0", 1'b0, 32'h0000_1000, 1'b0, 4, -1);
    idle_check("t2 idle2");
    burst("t2 d1", 1'b1, 32'h0000_3000, 1'b0, 4, -1);
    idle_check("t2 idle3");
    burst("t2 i1", 1'b0, 32'h0000_1000, 1'b0, 4, -1);
    ic_req = 1'b0; dc_req = 1'b0;
    idle_check("t2 after");

    // T3: dcache writeback at 0x2000, memory ready every third cycle
    dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h0000_2000; mem_ready = 1'b0;
    idle_check("t3 idle");
    for (int b = 0; b < 4; b++) begin
      for (int w = 0; w < 3; w++) begin
        mem_ready = (w == 2);
        @(negedge clk);
        check($sformatf("t3 b%0d w%0d mem_req", b, w), mem_req, 1);
        check($sformatf("t3 b%0d w%0d addr", b, w), mem_addr, 32'h0000_2000 + 32'(4 * b));
        check($sformatf("t3 b%0d w%0d wdata", b, w), mem_wdata, 32'hA0 + 32'(b));
        check($sformatf("t3 b%0d w%0d we", b, w), mem_we, 1);
        check($sformatf("t3 b%0d w%0d dc_rvalid", b, w), dc_rvalid, 0);
        check($sformatf("t3 b%0d w%0d dc_done", b, w), dc_done, (b == 3 && w == 2));
        next_cycle();
      end
    end
    dc_req = 1'b0; dc_we = 1'b0; mem_ready = 1'b1;
    idle_check("t3 after");

    // T4: icache drops req after beat 1; pending dcache request wins next
    ic_req = 1'b1; ic_addr = 32'h0000_4008;
    idle_check("t4 idle");
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h0000_5000;
    burst("t4 i", 1'b0, 32'h0000_4000, 1'b0, 4, 1);
    idle_check("t4 gap");
    burst("t4 d", 1'b1, 32'h0000_5000, 1'b0, 4, -1);
    dc_req = 1'b0;
    idle_check("t4 after");

    // T5: reset during beat 2 of a dcache fill
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h0000_6004;
    idle_check("t5 idle");
    burst("t5", 1'b1, 32'h0000_6000, 1'b0, 2, -1);
    rst = 1'b1; dc_req = 1'b0;
    @(negedge clk);
    check("t5 b2 addr", mem_addr, 32'h0000_6008);
    check("t5 b2 dc_done", dc_done, 0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("t5 post mem_req", mem_req, 0);
    check("t5 post dc_gnt", dc_gnt, 0);
    check("t5 post ic_gnt", ic_gnt, 0);
    check("t5 post dc_done", dc_done, 0);
    check("t5 post ic_done", ic_done, 0);
    next_cycle();
    ic_req = 1'b1; ic_addr = 32'h0000_7000;
    dc_req = 1'b1; dc_addr = 32'h0000_8000;
    idle_check("t5 tie idle");
    burst("t5 d", 1'b1, 32'h0000_8000, 1'b0, 1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
